seg_scan_capture: RTL

Receive side of the multiplexed seven-segment bus that the clock counter drives through the display refresher. The block samples the SEG/ENABLE lines and decodes each scanned segment pattern back to a BCD digit. It assembles the six digit slots into one validated HH:MM:SS frame and reports it with a one-cycle strobe. It is used for board-to-board display mirroring and as a self-check monitor on the display path.

---
 rtl/seg_scan_capture_pkg.sv | 56 +++++
 rtl/seg_scan_capture_seg7_to_bcd.sv | 33 +++
 rtl/seg_scan_capture.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_capture_pkg.sv
// Shared constants for the seven-segment scan receiver: segment codes, slot
// indices, FSM encoding, decoder result layout and the frame validity rule.
package seg_scan_capture_pkg;

    localparam int NUM_SLOTS = 6;

    // Segment patterns with bit0 = a ... bit6 = g, 1 = segment lit.
    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;

    localparam logic [2:0] SLOT_SEC  = 3'd0;
    localparam logic [2:0] SLOT_TSEC = 3'd1;
    localparam logic [2:0] SLOT_MIN  = 3'd2;
    localparam logic [2:0] SLOT_TMIN = 3'd3;
    localparam logic [2:0] SLOT_HR   = 3'd4;
    localparam logic [2:0] SLOT_THR  = 3'd5;

    localparam logic [5:0] MASK_FULL  = 6'b111111;
    localparam logic [5:0] MASK_SLOT0 = 6'b000001;

    // Value of the decoder's illegal flag when the pattern is not a digit.
    localparam logic ILLEGAL_CODE = 1'b1;

    typedef enum logic [1:0] {
        ST_SYNC    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_CHECK   = 2'd2
    } state_e;

    typedef struct packed {
        logic       illegal;
        logic [3:0] bcd;
    } dec_t;

    // Clock-counter frame rule: seconds/minutes tens 0..5, hours 00..12.
    function automatic logic frame_ok(input logic [3:0] tsec,
                                      input logic [3:0] tmin,
                                      input logic [3:0] hr,
                                      input logic [3:0] thr);
        logic ok;
        ok = (tsec <= 4'd5) && (tmin <= 4'd5) && (thr <= 4'd1);
        if (thr == 4'd1 && hr > 4'd2) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/seg_scan_capture_seg7_to_bcd.sv
// Inverse of the display refresher's encoder: lit-segment pattern to BCD digit,
// flagging any pattern that is not one of the ten digit shapes.
module seg7_to_bcd
    import seg_scan_capture_pkg::*;
(
    input  logic [6:0] pat_i,
    output logic       illegal_o,
    output logic [3:0] bcd_o
);

    dec_t dec;

    always_comb begin
        dec = '{illegal: 1'b0, bcd: 4'd0};
        case (pat_i)
            SEG_0:   dec.bcd = 4'd0;
            SEG_1:   dec.bcd = 4'd1;
            SEG_2:   dec.bcd = 4'd2;
            SEG_3:   dec.bcd = 4'd3;
            SEG_4:   dec.bcd = 4'd4;
            SEG_5:   dec.bcd = 4'd5;
            SEG_6:   dec.bcd = 4'd6;
            SEG_7:   dec.bcd = 4'd7;
            SEG_8:   dec.bcd = 4'd8;
            SEG_9:   dec.bcd = 4'd9;
            default: dec.illegal = ILLEGAL_CODE;
        endcase
    end

    assign illegal_o = dec.illegal;
    assign bcd_o     = dec.bcd;

endmodule

// File: rtl/seg_scan_capture.sv
// Samples a multiplexed seven-segment bus, filters each scanned slot for
// stability, decodes it and assembles validated HH:MM:SS frames.
module seg_scan_capture
    import seg_scan_capture_pkg::*;
#(
    parameter int STABLE_CYCLES = 16,
    parameter int FRAME_TIMEOUT = 65535
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] SEG,
    input  logic [5:0] ENABLE,
    output logic [3:0] seconds,
    output logic [3:0] t_secs,
    output logic [3:0] minutes,
    output logic [3:0] t_mins,
    output logic [3:0] hours,
    output logic [3:0] t_hours,
    output logic       time_valid,
    output logic       frame_err,
    output logic       display_lost
);

    localparam logic [7:0]  STAB_MAX = 8'(STABLE_CYCLES - 1);
    localparam logic [7:0]  STAB_PRE = 8'(STABLE_CYCLES - 2);
    localparam logic [15:0] TO_MAX   = 16'(FRAME_TIMEOUT);

    logic [13:0] sync1_q, sync2_q;
    logic [12:0] watch_s, prev_q;
    logic [6:0]  seg_s;
    logic [5:0]  en_s;
    logic        unused_dp_s;
    logic        changed_s, slot_active_s, capture_s, timeout_s;
    logic [2:0]  slot_s;
    logic [5:0]  slot_bit_s, mask_next_s;
    logic [7:0]  stab_q, stab_d;
    logic [15:0] to_q, to_d;
    logic        illegal_s;
    logic [3:0]  bcd_s;

    state_e          state_q;
    logic [5:0]      mask_q;
    logic [5:0][3:0] dig_q;
    logic [5:0][3:0] out_q;
    logic            time_valid_q, frame_err_q, lost_q;

    // Input synchronizer: idle level (all ones) is the reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
            prev_q  <= '1;
        end else begin
            sync1_q <= {ENABLE, SEG};
            sync2_q <= sync1_q;
            prev_q  <= watch_s;
        end
    end

    assign seg_s       = sync2_q[6:0];
    assign unused_dp_s = sync2_q[7];
    assign en_s        = sync2_q[13:8];
    assign watch_s     = {en_s, seg_s};
    assign changed_s   = (watch_s != prev_q);

    always_comb begin
        slot_s = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!en_s[i]) begin
                slot_s = 3'(i);
            end
        end
    end

    assign slot_active_s = $onehot(~en_s);
    assign slot_bit_s    = 6'b000001 << slot_s;
    assign mask_next_s   = mask_q | slot_bit_s;

    // Capture fires once, on the cycle the counter steps onto its saturation value.
    assign capture_s = slot_active_s && !changed_s && (stab_q == STAB_PRE);
    assign timeout_s = !capture_s && (to_q == TO_MAX);

    always_comb begin
        stab_d = stab_q;
        if (!slot_active_s || changed_s) begin
            stab_d = '0;
        end else if (stab_q != STAB_MAX) begin
            stab_d = stab_q + 8'd1;
        end
    end

    always_comb begin
        to_d = to_q;
        if (capture_s) begin
            to_d = '0;
        end else if (to_q != TO_MAX) begin
            to_d = to_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stab_q <= '0;
            to_q   <= '0;
        end else begin
            stab_q <= stab_d;
            to_q   <= to_d;
        end
    end

    seg7_to_bcd u_dec (
        .pat_i     (~seg_s),
        .illegal_o (illegal_s),
        .bcd_o     (bcd_s)
    );

    // Frame assembly FSM; all outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_SYNC;
            mask_q       <= '0;
            dig_q        <= '0;
            out_q        <= '0;
            time_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            lost_q       <= 1'b1;
        end else begin
            time_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            if (timeout_s) begin
                lost_q  <= 1'b1;
                state_q <= ST_SYNC;
                mask_q  <= '0;
            end else begin
                case (state_q)
                    ST_SYNC: begin
                        if (capture_s && slot_s == SLOT_SEC && !illegal_s) begin
                            dig_q[SLOT_SEC] <= bcd_s;
                            mask_q          <= MASK_SLOT0;
                            state_q         <= ST_COLLECT;
                        end
                    end
                    ST_COLLECT: begin
                        // An empty mask means a frame was just checked: only slot 0 may open the next.
                        if (capture_s && (mask_q != '0 || slot_s == SLOT_SEC)) begin
                            if (illegal_s) begin
                                frame_err_q <= 1'b1;
                                state_q     <= ST_SYNC;
                                mask_q      <= '0;
                            end else if (mask_q[slot_s]) begin
                                if (slot_s == SLOT_SEC) begin
                                    dig_q[SLOT_SEC] <= bcd_s;
                                    mask_q          <= MASK_SLOT0;
                                end else begin
                                    frame_err_q <= 1'b1;
                                    state_q     <= ST_SYNC;
                                    mask_q      <= '0;
                                end
                            end else begin
                                dig_q[slot_s] <= bcd_s;
                                mask_q        <= mask_next_s;
                                if (mask_next_s == MASK_FULL) begin
                                    state_q <= ST_CHECK;
                                end
                            end
                        end
                    end
                    ST_CHECK: begin
                        if (frame_ok(dig_q[SLOT_TSEC], dig_q[SLOT_TMIN],
                                     dig_q[SLOT_HR], dig_q[SLOT_THR])) begin
                            out_q        <= dig_q;
                            time_valid_q <= 1'b1;
                            lost_q       <= 1'b0;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                        state_q <= ST_COLLECT;
                        mask_q  <= '0;
                    end
                    default: begin
                        state_q <= ST_SYNC;
                        mask_q  <= '0;
                    end
                endcase
            end
        end
    end

    assign seconds      = out_q[SLOT_SEC];
    assign t_secs       = out_q[SLOT_TSEC];
    assign minutes      = out_q[SLOT_MIN];
    assign t_mins       = out_q[SLOT_TMIN];
    assign hours        = out_q[SLOT_HR];
    assign t_hours      = out_q[SLOT_THR];
    assign time_valid   = time_valid_q;
    assign frame_err    = frame_err_q;
    assign display_lost = lost_q;

endmodule
